// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: stage count, slice
// geometry helpers and the packed status-flag bit order.
package addsub_pkg;

    // Packed status order: {NEG, ZERO, OVF, COUT} = bits 3..0
    localparam int unsigned FlagCout = 0;
    localparam int unsigned FlagOvf  = 1;
    localparam int unsigned FlagZero = 2;
    localparam int unsigned FlagNeg  = 3;
    localparam int unsigned NumFlags = 4;

    function automatic int unsigned stages(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Bit index of the lowest bit of slice k
    function automatic int unsigned slice_lo(input int unsigned k, input int unsigned chunk);
        return k * chunk;
    endfunction

    // Operand bits still to be added when entering stage k
    function automatic int unsigned rem_width(input int unsigned width, input int unsigned chunk,
                                              input int unsigned k);
        return width - k * chunk;
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// One CHUNK-bit slice of the pipelined adder: combinational add followed by
// sum/carry/partial-zero/valid registers that hold when en is low.
module addsub_stage #(
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_prev,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    input  logic             zero_prev,
    output logic             valid,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             zero
);

    logic [CHUNK:0]   total;
    logic             valid_q;
    logic [CHUNK-1:0] sum_q;
    logic             cout_q;
    logic             zero_q;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else if (en) begin
            valid_q <= valid_prev;
            sum_q   <= total[CHUNK-1:0];
            cout_q  <= total[CHUNK];
            // Accumulates zero-ness of this slice and every slice below it
            zero_q  <= zero_prev && (total[CHUNK-1:0] == '0);
        end
    end

    assign valid = valid_q;
    assign sum   = sum_q;
    assign cout  = cout_q;
    assign zero  = zero_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor, one CHUNK-bit slice per stage,
// with a global-stall valid/ready handshake and status flags on the result.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_neg
);

    localparam int unsigned STAGES = stages(WIDTH, CHUNK);
    localparam int unsigned LAST   = STAGES - 1;

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = in_sub ? ~in_b : in_b;
    assign cin_eff  = in_cin ^ in_sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned RW = rem_width(WIDTH, CHUNK, k);
        localparam int unsigned AW = slice_lo(k, CHUNK);

        logic [RW-1:0]       rem_a;
        logic [RW-1:0]       rem_b;
        logic                c_prev;
        logic                z_prev;
        logic                v_prev;
        logic                valid_q;
        logic [CHUNK-1:0]    sum_q;
        logic                cout_q;
        logic                zero_q;
        // Sum slices finished so far, aligned with this stage's output
        logic [AW+CHUNK-1:0] acc;

        if (k == 0) begin : g_first
            assign rem_a  = in_a;
            assign rem_b  = b_eff;
            assign c_prev = cin_eff;
            assign z_prev = 1'b1;
            assign v_prev = in_valid;
            assign acc    = sum_q;
        end else begin : g_rest
            logic [RW-1:0] rem_a_q;
            logic [RW-1:0] rem_b_q;
            logic [AW-1:0] low_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rem_a_q <= '0;
                    rem_b_q <= '0;
                    low_q   <= '0;
                end else if (en) begin
                    rem_a_q <= g_stage[k-1].rem_a[RW+CHUNK-1:CHUNK];
                    rem_b_q <= g_stage[k-1].rem_b[RW+CHUNK-1:CHUNK];
                    low_q   <= g_stage[k-1].acc;
                end
            end

            assign rem_a  = rem_a_q;
            assign rem_b  = rem_b_q;
            assign c_prev = g_stage[k-1].cout_q;
            assign z_prev = g_stage[k-1].zero_q;
            assign v_prev = g_stage[k-1].valid_q;
            assign acc    = {sum_q, low_q};
        end

        addsub_stage #(
            .CHUNK(CHUNK)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .valid_prev(v_prev),
            .a         (rem_a[CHUNK-1:0]),
            .b         (rem_b[CHUNK-1:0]),
            .cin       (c_prev),
            .zero_prev (z_prev),
            .valid     (valid_q),
            .sum       (sum_q),
            .cout      (cout_q),
            .zero      (zero_q)
        );
    end

    // Operand sign bits travel alongside the top slice for the overflow test
    logic a_msb_q;
    logic b_msb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (en) begin
            a_msb_q <= g_stage[LAST].rem_a[CHUNK-1];
            b_msb_q <= g_stage[LAST].rem_b[CHUNK-1];
        end
    end

    logic [NumFlags-1:0] flags;

    assign out_sum   = g_stage[LAST].acc;
    assign out_valid = g_stage[LAST].valid_q;

    always_comb begin
        flags           = '0;
        flags[FlagCout] = g_stage[LAST].cout_q;
        flags[FlagOvf]  = (a_msb_q == b_msb_q) && (out_sum[WIDTH-1] != a_msb_q);
        flags[FlagZero] = g_stage[LAST].zero_q;
        flags[FlagNeg]  = out_sum[WIDTH-1];
    end

    assign out_cout = flags[FlagCout];
    assign out_ovf  = flags[FlagOvf];
    assign out_zero = flags[FlagZero];
    assign out_neg  = flags[FlagNeg];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub in three geometries: W16/C4, W8/C8, W32/C8.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Index 0: W16/C4, 1: W8/C8, 2: W32/C8
    logic        iv[3];
    logic        isub[3];
    logic        icin[3];
    logic        ordy[3];
    logic        irdy[3];
    logic        ov[3];
    logic        oc[3];
    logic        oo[3];
    logic        oz[3];
    logic        on[3];
    logic [15:0] a16, b16, s16;
    logic [7:0]  a8, b8, s8;
    logic [31:0] a32, b32, s32;

    pipelined_addsub #(.WIDTH(16), .CHUNK(4)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_a(a16), .in_b(b16),
        .in_sub(isub[0]), .in_cin(icin[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_sum(s16), .out_cout(oc[0]), .out_ovf(oo[0]), .out_zero(oz[0]), .out_neg(on[0])
    );

    pipelined_addsub #(.WIDTH(8), .CHUNK(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_a(a8), .in_b(b8),
        .in_sub(isub[1]), .in_cin(icin[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_sum(s8), .out_cout(oc[1]), .out_ovf(oo[1]), .out_zero(oz[1]), .out_neg(on[1])
    );

    pipelined_addsub #(.WIDTH(32), .CHUNK(8)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_a(a32), .in_b(b32),
        .in_sub(isub[2]), .in_cin(icin[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_sum(s32), .out_cout(oc[2]), .out_ovf(oo[2]), .out_zero(oz[2]), .out_neg(on[2])
    );

    typedef struct {
        int          cfg;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] sum;
        logic [3:0]  flags;  // {neg, zero, ovf, cout}
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int cfg, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin);
        iv[cfg]   = v;
        isub[cfg] = sub;
        icin[cfg] = cin;
        case (cfg)
            0:       begin a16 = a[15:0]; b16 = b[15:0]; end
            1:       begin a8 = a[7:0]; b8 = b[7:0]; end
            default: begin a32 = a; b32 = b; end
        endcase
    endtask

    function automatic logic [31:0] dut_sum(input int cfg);
        case (cfg)
            0:       return {16'h0, s16};
            1:       return {24'h0, s8};
            default: return s32;
        endcase
    endfunction

    function automatic logic [3:0] dut_flags(input int cfg);
        return {on[cfg], oz[cfg], oo[cfg], oc[cfg]};
    endfunction

    // Arithmetic reference: returns {flags, sum} for a given width
    function automatic logic [35:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic cin);
        logic [63:0] m, ae, be, t, s;
        logic        ovf;
        m   = (64'd1 << w) - 64'd1;
        ae  = {32'h0, a} & m;
        be  = (sub ? ~{32'h0, b} : {32'h0, b}) & m;
        t   = ae + be + {63'h0, cin ^ sub};
        s   = t & m;
        ovf = (ae[w-1] == be[w-1]) && (s[w-1] != ae[w-1]);
        return {s[w-1], (s == 64'h0), ovf, t[w], s[31:0]};
    endfunction

    vec_t      tbl[15];
    logic [35:0] exp_q[$];

    initial begin
        tbl = '{
            '{0, 4, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 4'b0000},
            '{0, 4, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b0101},
            '{0, 4, 32'h0000_8000, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_7FFF, 4'b0011},
            '{0, 4, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_FFFD, 4'b1000},
            '{0, 4, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_8000, 4'b1010},
            '{0, 4, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 32'h0000_0000, 4'b0101},
            '{0, 4, 32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100, 4'b0000},
            '{1, 1, 32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 4'b0000},
            '{1, 1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b0101},
            '{1, 1, 32'h0000_0080, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_007F, 4'b0011},
            '{1, 1, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_00FD, 4'b1000},
            '{2, 4, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 4'b0000},
            '{2, 4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b0101},
            '{2, 4, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 4'b0011},
            '{2, 4, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFD, 4'b1000}
        };

        for (int c = 0; c < 3; c++) begin
            drive(c, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            ordy[c] = 1'b1;
        end

        // Reset state
        #12;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("rst_valid[%0d]", c), {31'h0, ov[c]}, 32'h0);
            check($sformatf("rst_sum[%0d]", c), dut_sum(c), 32'h0);
            check($sformatf("rst_flags[%0d]", c), {28'h0, dut_flags(c)}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int c = 0; c < 3; c++)
            check($sformatf("rst_ready[%0d]", c), {31'h0, irdy[c]}, 32'h1);

        // Single-beat vectors: latency, sum, flags
        for (int i = 0; i < 15; i++) begin
            int c;
            int lat;
            c = tbl[i].cfg;
            @(negedge clk);
            drive(c, 1'b1, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin);
            @(posedge clk);
            #1;
            iv[c] = 1'b0;
            lat = 1;
            while (!ov[c] && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("v%0d_sum", i), dut_sum(c), tbl[i].sum);
            check($sformatf("v%0d_flags", i), {28'h0, dut_flags(c)}, {28'h0, tbl[i].flags});
        end

        // Eight back-to-back beats on W16, downstream stalled in cycles 5..7
        begin
            int sent;
            int got;
            logic [31:0] a, b;
            logic        sub, cin;
            logic [35:0] e;
            sent = 0;
            got  = 0;
            for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
                @(negedge clk);
                ordy[0] = !(cyc >= 5 && cyc <= 7);
                a   = 32'h3C5A + 32'h1111 * sent;
                b   = 32'hF00F ^ (32'h0123 * sent);
                sub = sent[0];
                cin = sent[1];
                drive(0, sent < 8, a, b, sub, cin);
                #1;
                if (cyc >= 5 && cyc <= 7)
                    check($sformatf("stall_in_ready_c%0d", cyc), {31'h0, irdy[0]}, 32'h0);
                if (ov[0]) begin
                    if (exp_q.size() == 0) begin
                        check("stream_extra_beat", {31'h0, ov[0]}, 32'h0);
                    end else begin
                        e = exp_q[0];
                        check($sformatf("stream_sum_c%0d", cyc), dut_sum(0), e[31:0]);
                        check($sformatf("stream_flags_c%0d", cyc), {28'h0, dut_flags(0)},
                              {28'h0, e[35:32]});
                        if (ordy[0]) begin
                            void'(exp_q.pop_front());
                            got++;
                        end
                    end
                end
                if (iv[0] && irdy[0]) begin
                    exp_q.push_back(model(16, a, b, sub, cin));
                    sent++;
                end
            end
            check("stream_beats_out", got, 8);
            @(negedge clk);
            drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            ordy[0] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check($sformatf("stream_drained_%0d", i), {31'h0, ov[0]}, 32'h0);
            end
        end

        // Asynchronous reset with the W16 pipe full and stalled
        ordy[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(0, 1'b1, 32'h1234 + i, 32'h0101, 1'b0, 1'b0);
        end
        @(negedge clk);
        check("pre_rst_valid", {31'h0, ov[0]}, 32'h1);
        check("pre_rst_sum", dut_sum(0), 32'h1335);
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'h0, ov[0]}, 32'h0);
        check("midrst_sum", dut_sum(0), 32'h0);
        check("midrst_flags", {28'h0, dut_flags(0)}, 32'h0);
        @(negedge clk);
        rst     = 1'b0;
        ordy[0] = 1'b1;
        #1;
        check("post_rst_ready", {31'h0, irdy[0]}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("no_stale_%0d", i), {31'h0, ov[0]}, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
